// File: rtl/fpu_merge_pkg.sv
// Shared constants and types for the split high/low FPU result merge stage.
// Default widths match the three-port, four-stage datapath this block replaces.
package fpu_merge_pkg;

    localparam int DEF_NPORT  = 3;
    localparam int DEF_OPW    = 13;
    localparam int DEF_RETW   = 14;
    localparam int DEF_FLW    = 6;
    localparam int DEF_RAISEW = 11;
    localparam int DEF_LAT    = 4;

    // Low byte of the double-precision compare op; its flags come from the high half.
    localparam logic [7:0] FOP_CMPDH = 8'h4B;

    typedef struct packed {
        logic               v;
        logic [DEF_OPW-1:0] op;
    } stage_t;

    function automatic logic is_cmpdh(input logic [7:0] op_lo);
        return (op_lo == FOP_CMPDH);
    endfunction

endpackage

// File: rtl/fpu_op_delay.sv
// One-port valid/op shift register, LAT stages deep, with pipeline flush.
// Only the valid bit is flush-qualified; the op field just follows along.
module fpu_op_delay
    import fpu_merge_pkg::*;
#(
    parameter int OPW = DEF_OPW,
    parameter int LAT = DEF_LAT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issue,
    input  logic           flush,
    input  logic [OPW-1:0] op,
    output logic           last_v,
    output logic [OPW-1:0] last_op
);

    logic [LAT-1:0]          v_r;
    logic [LAT-1:0][OPW-1:0] op_r;

    // Shift valid/op one stage per cycle; flush clears every valid being captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_r  <= '0;
            op_r <= '0;
        end else begin
            v_r[0]  <= issue & ~flush;
            op_r[0] <= op;
            for (int k = 1; k < LAT; k++) begin
                v_r[k]  <= v_r[k-1] & ~flush;
                op_r[k] <= op_r[k-1];
            end
        end
    end

    assign last_v  = v_r[LAT-1];
    assign last_op = op_r[LAT-1];

endmodule

// File: rtl/fpu_half_merge.sv
// Merges the fun_fpuH/fun_fpuL half results per issue port: flag steering,
// return-tag merge, tag-conflict detection and the sticky exception register.
module fpu_half_merge
    import fpu_merge_pkg::*;
#(
    parameter int NPORT  = DEF_NPORT,
    parameter int OPW    = DEF_OPW,
    parameter int RETW   = DEF_RETW,
    parameter int FLW    = DEF_FLW,
    parameter int RAISEW = DEF_RAISEW,
    parameter int LAT    = DEF_LAT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORT-1:0][3:0]        u_en,
    input  logic [NPORT-1:0][OPW-1:0]    u_op,
    input  logic                         flush,
    input  logic [NPORT-1:0][RETW-1:0]   retL,
    input  logic [NPORT-1:0][RETW-1:0]   retH,
    input  logic [NPORT-1:0]             retL_en,
    input  logic [NPORT-1:0]             retH_en,
    input  logic [NPORT-1:0][FLW-1:0]    FOOSL_lo,
    input  logic [NPORT-1:0][FLW-1:0]    FOOSL_hi,
    input  logic [NPORT-1:0][RAISEW-1:0] raise_s,
    input  logic                         sticky_clr,
    output logic [NPORT-1:0][RETW-1:0]   u_ret,
    output logic [NPORT-1:0]             u_ret_en,
    output logic [NPORT-1:0][FLW-1:0]    FUS,
    output logic [NPORT-1:0]             fus_vld,
    output logic [RAISEW-1:0]            sticky,
    output logic                         ret_conflict
);

    logic [NPORT-1:0]           last_v_s;
    logic [NPORT-1:0][OPW-1:0]  last_op_s;
    logic [NPORT-1:0][FLW-1:0]  fus_s;
    logic [NPORT-1:0][RETW-1:0] ret_s;
    logic [NPORT-1:0]           ret_en_s;
    logic                       conflict_s;
    logic [RAISEW-1:0]          raise_or_s;
    logic [RAISEW-1:0]          sticky_nxt_s;
    logic [RAISEW-1:0]          sticky_r;
    logic                       ret_conflict_r;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        fpu_op_delay #(
            .OPW (OPW),
            .LAT (LAT)
        ) u_delay (
            .clk     (clk),
            .rst     (rst),
            .issue   (|u_en[p]),
            .flush   (flush),
            .op      (u_op[p]),
            .last_v  (last_v_s[p]),
            .last_op (last_op_s[p])
        );
    end

    // Steer compare flags from the high half for cmpDH, low half otherwise.
    always_comb begin
        fus_s = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (!last_v_s[p]) begin
                fus_s[p] = '0;
            end else if (is_cmpdh(last_op_s[p][7:0])) begin
                fus_s[p] = FOOSL_hi[p];
            end else begin
                fus_s[p] = FOOSL_lo[p];
            end
        end
    end

    // Merge half return tags and flag ports where both halves disagree.
    always_comb begin
        ret_s      = '0;
        ret_en_s   = '0;
        conflict_s = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            ret_s[p]    = retL[p] | retH[p];
            ret_en_s[p] = retL_en[p] | retH_en[p];
            if (retL_en[p] && retH_en[p] && (retL[p] != retH[p])) begin
                conflict_s = 1'b1;
            end else begin
                conflict_s = conflict_s;
            end
        end
    end

    // Completing raises are ORed in after the clear, so a same-cycle raise survives.
    always_comb begin
        raise_or_s = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (last_v_s[p]) begin
                raise_or_s = raise_or_s | raise_s[p];
            end else begin
                raise_or_s = raise_or_s;
            end
        end
        if (sticky_clr) begin
            sticky_nxt_s = raise_or_s;
        end else begin
            sticky_nxt_s = sticky_r | raise_or_s;
        end
    end

    // Sticky exception and conflict registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_r       <= '0;
            ret_conflict_r <= 1'b0;
        end else begin
            sticky_r       <= sticky_nxt_s;
            ret_conflict_r <= ret_conflict_r | conflict_s;
        end
    end

    assign u_ret        = ret_s;
    assign u_ret_en     = ret_en_s;
    assign FUS          = fus_s;
    assign fus_vld      = last_v_s;
    assign sticky       = sticky_r;
    assign ret_conflict = ret_conflict_r;

endmodule

// File: tb/tb_fpu_half_merge.sv
// Directed plus random bench for fpu_half_merge against a cycle-history model.
module tb_fpu_half_merge;
    import fpu_merge_pkg::*;

    localparam int NPORT = 3, OPW = 13, RETW = 14, FLW = 6, RAISEW = 11, LAT = 4;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic rst;
    logic [NPORT-1:0][3:0]        u_en;
    logic [NPORT-1:0][OPW-1:0]    u_op;
    logic                         flush;
    logic [NPORT-1:0][RETW-1:0]   retL, retH;
    logic [NPORT-1:0]             retL_en, retH_en;
    logic [NPORT-1:0][FLW-1:0]    FOOSL_lo, FOOSL_hi;
    logic [NPORT-1:0][RAISEW-1:0] raise_s;
    logic                         sticky_clr;
    logic [NPORT-1:0][RETW-1:0]   u_ret;
    logic [NPORT-1:0]             u_ret_en;
    logic [NPORT-1:0][FLW-1:0]    FUS;
    logic [NPORT-1:0]             fus_vld;
    logic [RAISEW-1:0]            sticky;
    logic                         ret_conflict;

    fpu_half_merge #(.NPORT(NPORT), .OPW(OPW), .RETW(RETW), .FLW(FLW),
                     .RAISEW(RAISEW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .u_en(u_en), .u_op(u_op), .flush(flush),
        .retL(retL), .retH(retH), .retL_en(retL_en), .retH_en(retH_en),
        .FOOSL_lo(FOOSL_lo), .FOOSL_hi(FOOSL_hi), .raise_s(raise_s),
        .sticky_clr(sticky_clr), .u_ret(u_ret), .u_ret_en(u_ret_en),
        .FUS(FUS), .fus_vld(fus_vld), .sticky(sticky), .ret_conflict(ret_conflict)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Per-cycle input history: an op issued in cycle s completes in cycle s+LAT
    // unless flush was high in any cycle s .. s+LAT-1.
    bit             iss_h [MAXC][NPORT];
    logic [OPW-1:0] op_h  [MAXC][NPORT];
    bit             fl_h  [MAXC];
    logic [RAISEW-1:0] sticky_m = '0;
    bit                conf_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_v(input int p);
        int s;
        s = cyc - LAT;
        if (s < 0) return 1'b0;
        if (!iss_h[s][p]) return 1'b0;
        for (int c = s; c < cyc; c++) if (fl_h[c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic idle();
        u_en = '0; u_op = '0; flush = 1'b0; retL = '0; retH = '0;
        retL_en = '0; retH_en = '0; raise_s = '0; sticky_clr = 1'b0;
    endtask

    // Check the current cycle against the model, record inputs, advance one clock.
    task automatic step();
        logic [RAISEW-1:0] rs;
        logic [OPW-1:0]    eo;
        logic [FLW-1:0]    ef;
        bit                ev, cf;
        #1;
        rs = '0;
        cf = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            ev = exp_v(p);
            eo = (cyc >= LAT) ? op_h[cyc-LAT][p] : '0;
            ef = !ev ? '0 : ((eo[7:0] == FOP_CMPDH) ? FOOSL_hi[p] : FOOSL_lo[p]);
            chk("fus_vld", 64'(fus_vld[p]), 64'(ev));
            chk("FUS", 64'(FUS[p]), 64'(ef));
            chk("u_ret", 64'(u_ret[p]), 64'(retL[p] | retH[p]));
            chk("u_ret_en", 64'(u_ret_en[p]), 64'(retL_en[p] | retH_en[p]));
            if (ev) rs = rs | raise_s[p];
            if (retL_en[p] && retH_en[p] && (retL[p] != retH[p])) cf = 1'b1;
        end
        chk("sticky", 64'(sticky), 64'(sticky_m));
        chk("ret_conflict", 64'(ret_conflict), 64'(conf_m));
        for (int p = 0; p < NPORT; p++) begin
            iss_h[cyc][p] = (u_en[p] != 4'h0);
            op_h[cyc][p]  = u_op[p];
        end
        fl_h[cyc] = flush;
        sticky_m = (sticky_clr ? '0 : sticky_m) | rs;
        conf_m   = conf_m | cf;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_vld"}, 64'(fus_vld), 64'd0);
        chk({tag, "_fus"}, 64'(FUS), 64'd0);
        chk({tag, "_sticky"}, 64'(sticky), 64'd0);
        chk({tag, "_conf"}, 64'(ret_conflict), 64'd0);
    endtask

    initial begin
        logic [OPW-1:0] rop;
        idle();
        FOOSL_lo = '0; FOOSL_hi = '0;
        rst = 1'b1;
        #12;
        check_reset_outs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Basic steering: cmpDH takes the high flags, another op the low ones.
        for (int p = 0; p < NPORT; p++) begin
            FOOSL_hi[p] = 6'h15; FOOSL_lo[p] = 6'h2A;
        end
        u_en[0] = 4'b0100; u_op[0] = {5'h13, FOP_CMPDH};
        step(); idle();
        for (int i = 0; i < 6; i++) step();
        u_en[0] = 4'b0001; u_op[0] = 13'h0012;
        step(); idle();
        for (int i = 0; i < 6; i++) step();

        // Flush on the third of three issue cycles.
        for (int i = 0; i < 3; i++) begin
            u_en = {NPORT{4'b1000}};
            for (int p = 0; p < NPORT; p++) u_op[p] = (p == 1) ? {5'h00, FOP_CMPDH} : 13'h0100;
            flush = (i == 2);
            step();
        end
        idle();
        for (int i = 0; i < 6; i++) step();

        // Sticky accumulate, then clear with a same-cycle raise.
        u_en[1] = 4'b0010; u_op[1] = 13'h0033;
        step(); idle();
        raise_s[0] = 11'h400;
        for (int i = 0; i < LAT - 1; i++) step();
        raise_s[1] = 11'h004;
        step(); idle();
        step(); step();
        u_en[2] = 4'b0010; u_op[2] = 13'h0044;
        step(); idle();
        for (int i = 0; i < LAT - 1; i++) step();
        sticky_clr = 1'b1; raise_s[2] = 11'h010;
        step(); idle();
        step(); step();

        // Return merge: equal tags do not conflict, different tags do.
        retL_en[0] = 1'b1; retH_en[0] = 1'b1; retL[0] = 14'h0011; retH[0] = 14'h0011;
        step();
        retH[0] = 14'h0012;
        step(); idle();
        for (int i = 0; i < 3; i++) step();

        // Asynchronous reset between edges with four ops in flight on port 0.
        for (int i = 0; i < 4; i++) begin
            u_en[0] = 4'b1111; u_op[0] = {5'h01, FOP_CMPDH};
            step();
        end
        idle();
        #2 rst = 1'b1;
        #1 check_reset_outs("midrst");
        #1 rst = 1'b0;
        for (int c = 0; c < cyc; c++)
            for (int p = 0; p < NPORT; p++) iss_h[c][p] = 1'b0;
        sticky_m = '0;
        conf_m   = 1'b0;
        for (int i = 0; i < LAT + 2; i++) step();

        // Random traffic, back-to-back issue allowed on every port.
        for (int i = 0; i < 500; i++) begin
            for (int p = 0; p < NPORT; p++) begin
                u_en[p] = ($urandom_range(0, 3) != 0) ? 4'($urandom) : 4'h0;
                rop = OPW'($urandom);
                if ($urandom_range(0, 2) == 0) rop[7:0] = FOP_CMPDH;
                u_op[p]     = rop;
                FOOSL_lo[p] = FLW'($urandom);
                FOOSL_hi[p] = FLW'($urandom);
                raise_s[p]  = RAISEW'($urandom) & RAISEW'($urandom);
                retL[p]     = RETW'($urandom);
                retH[p]     = ($urandom_range(0, 1) == 0) ? retL[p] : RETW'($urandom);
                retL_en[p]  = 1'($urandom);
                retH_en[p]  = ($urandom_range(0, 7) == 0) ? 1'($urandom) : 1'b0;
            end
            flush      = ($urandom_range(0, 15) == 0);
            sticky_clr = ($urandom_range(0, 11) == 0);
            step();
        end
        idle();
        for (int i = 0; i < LAT + 1; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
